// File: rtl/uio_port_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : uio_port_ctrl                                                   |
// | Brief    : Bus-mapped bidirectional GPIO with synchroniser, edge capture   |
// |            and sticky W1C flags driving a level interrupt.                 |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module uio_port_ctrl #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             wr_en,
    input  logic             rd_en,
    input  logic [2:0]       addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             rvalid,
    input  logic [WIDTH-1:0] pad_in,
    output logic [WIDTH-1:0] pad_out,
    output logic [WIDTH-1:0] pad_oe,
    output logic             irq
);

    localparam logic [2:0] c_addr_dir   = 3'd0;
    localparam logic [2:0] c_addr_out   = 3'd1;
    localparam logic [2:0] c_addr_in    = 3'd2;
    localparam logic [2:0] c_addr_rise  = 3'd3;
    localparam logic [2:0] c_addr_fall  = 3'd4;
    localparam logic [2:0] c_addr_flags = 3'd5;
    localparam logic [2:0] c_addr_tgl   = 3'd6;

    logic [WIDTH-1:0] r_sync [SYNC_STAGES];
    logic [WIDTH-1:0] r_dir;
    logic [WIDTH-1:0] r_out;
    logic [WIDTH-1:0] r_rise_en;
    logic [WIDTH-1:0] r_fall_en;
    logic [WIDTH-1:0] r_flags;
    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] r_rdata;
    logic             r_rvalid;

    logic [WIDTH-1:0] w_in_q;
    logic [WIDTH-1:0] w_rd_mux;
    logic [WIDTH-1:0] w_clr;
    logic [WIDTH-1:0] w_set;
    logic             w_wr_stb;
    logic             w_rd_stb;

    // Synchroniser keeps running while ena is low so edges seen after
    // re-enable are measured against a settled history.
    for (genvar s = 0; s < SYNC_STAGES; s++) begin : g_sync
        if (s == 0) begin : g_first
            always_ff @(posedge clk) begin
                if (!rst_n) r_sync[s] <= '0;
                else        r_sync[s] <= pad_in;
            end
        end else begin : g_next
            always_ff @(posedge clk) begin
                if (!rst_n) r_sync[s] <= '0;
                else        r_sync[s] <= r_sync[s-1];
            end
        end
    end

    assign w_in_q   = r_sync[SYNC_STAGES-1];
    assign w_wr_stb = wr_en & ena;
    assign w_rd_stb = rd_en & ena;
    assign w_clr    = (w_wr_stb && (addr == c_addr_flags)) ? wdata : '0;
    assign w_set    = (w_in_q & ~r_prev & r_rise_en) | (~w_in_q & r_prev & r_fall_en);

    always_comb begin
        w_rd_mux = '0;
        case (addr)
            c_addr_dir:   w_rd_mux = r_dir;
            c_addr_out:   w_rd_mux = r_out;
            c_addr_in:    w_rd_mux = w_in_q;
            c_addr_rise:  w_rd_mux = r_rise_en;
            c_addr_fall:  w_rd_mux = r_fall_en;
            c_addr_flags: w_rd_mux = r_flags;
            default:      w_rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_dir     <= '0;
            r_out     <= '0;
            r_rise_en <= '0;
            r_fall_en <= '0;
            r_flags   <= '0;
            r_prev    <= '0;
            r_rdata   <= '0;
            r_rvalid  <= 1'b0;
        end else begin
            r_prev   <= w_in_q;
            r_rvalid <= w_rd_stb;
            // Read samples pre-write state, so a same-cycle write is not visible.
            if (w_rd_stb) r_rdata <= w_rd_mux;
            if (w_wr_stb) begin
                case (addr)
                    c_addr_dir:  r_dir     <= wdata;
                    c_addr_out:  r_out     <= wdata;
                    c_addr_rise: r_rise_en <= wdata;
                    c_addr_fall: r_fall_en <= wdata;
                    c_addr_tgl:  r_out     <= r_out ^ wdata;
                    default:     ;
                endcase
            end
            // Set term is OR-ed after the clear so a coincident edge wins.
            if (ena) r_flags <= (r_flags & ~w_clr) | w_set;
        end
    end

    assign rdata   = r_rdata;
    assign rvalid  = r_rvalid;
    assign pad_out = r_out;
    assign pad_oe  = r_dir & {WIDTH{ena}};
    assign irq     = |r_flags;

endmodule
`default_nettype wire

// File: tb/tb_uio_port_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_uio_port_ctrl                                                |
// | Brief    : Directed self-checking bench for uio_port_ctrl (WIDTH=8).       |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_uio_port_ctrl;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             ena;
    logic             wr_en;
    logic             rd_en;
    logic [2:0]       addr;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] rdata;
    logic             rvalid;
    logic [WIDTH-1:0] pad_in;
    logic [WIDTH-1:0] pad_out;
    logic [WIDTH-1:0] pad_oe;
    logic             irq;

    int total = 0;
    int bad   = 0;

    uio_port_ctrl #(.WIDTH(WIDTH), .SYNC_STAGES(2)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ena    (ena),
        .wr_en  (wr_en),
        .rd_en  (rd_en),
        .addr   (addr),
        .wdata  (wdata),
        .rdata  (rdata),
        .rvalid (rvalid),
        .pad_in (pad_in),
        .pad_out(pad_out),
        .pad_oe (pad_oe),
        .irq    (irq)
    );

    always #5 clk = ~clk;

    // All stimulus changes and samples happen 1 time unit after a rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [2:0] a, input logic [WIDTH-1:0] d);
        wr_en = 1'b1; addr = a; wdata = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic do_read(input logic [2:0] a, output logic [WIDTH-1:0] d, output logic v);
        rd_en = 1'b1; addr = a;
        tick();
        rd_en = 1'b0;
        d = rdata;
        v = rvalid;
    endtask

    task automatic test_reset();
        logic [WIDTH-1:0] d;
        logic             v;
        rst_n = 1'b0; ena = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
        addr = '0; wdata = '0; pad_in = '0;
        repeat (3) tick();
        total++; if (pad_oe !== 8'h00 || pad_out !== 8'h00 || irq !== 1'b0 || rvalid !== 1'b0) begin
            bad++; $display("FAIL reset_outputs: oe=%h out=%h irq=%b rvalid=%b want 00 00 0 0", pad_oe, pad_out, irq, rvalid);
        end
        rst_n = 1'b1;
        tick();
        for (int a = 0; a < 8; a++) begin
            do_read(3'(a), d, v);
            total++; if (d !== 8'h00 || v !== 1'b1) begin
                bad++; $display("FAIL reset_read addr=%0d: rdata=%h rvalid=%b want 00 1", a, d, v);
            end
            tick();
            total++; if (rvalid !== 1'b0) begin
                bad++; $display("FAIL rvalid_drop addr=%0d: rvalid=%b want 0", a, rvalid);
            end
        end
    endtask

    task automatic test_outputs();
        logic [WIDTH-1:0] d;
        logic             v;
        do_write(3'd0, 8'hF0);
        do_write(3'd1, 8'hA5);
        do_write(3'd6, 8'h0F);
        total++; if (pad_oe !== 8'hF0 || pad_out !== 8'hAA) begin
            bad++; $display("FAIL pad_drive: oe=%h out=%h want F0 AA", pad_oe, pad_out);
        end
        do_read(3'd1, d, v);
        total++; if (d !== 8'hAA || v !== 1'b1) begin
            bad++; $display("FAIL read_out: rdata=%h rvalid=%b want AA 1", d, v);
        end
        do_read(3'd6, d, v);
        total++; if (d !== 8'h00) begin
            bad++; $display("FAIL read_tgl: rdata=%h want 00", d);
        end
        do_read(3'd7, d, v);
        total++; if (d !== 8'h00) begin
            bad++; $display("FAIL read_reserved: rdata=%h want 00", d);
        end
        ena = 1'b0;
        #1;
        total++; if (pad_oe !== 8'h00 || pad_out !== 8'hAA) begin
            bad++; $display("FAIL ena_low_pads: oe=%h out=%h want 00 AA", pad_oe, pad_out);
        end
        do_write(3'd0, 8'h0F);
        do_read(3'd0, d, v);
        total++; if (v !== 1'b0) begin
            bad++; $display("FAIL ena_low_read: rvalid=%b want 0", v);
        end
        ena = 1'b1;
        #1;
        total++; if (pad_oe !== 8'hF0) begin
            bad++; $display("FAIL ena_low_write_ignored: oe=%h want F0", pad_oe);
        end
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] d;
        wr_en = 1'b1; rd_en = 1'b1; addr = 3'd1; wdata = 8'h3C;
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        total++; if (rdata !== 8'hAA || rvalid !== 1'b1 || pad_out !== 8'h3C) begin
            bad++; $display("FAIL rw_same_cycle: rdata=%h rvalid=%b out=%h want AA 1 3C", rdata, rvalid, pad_out);
        end
        tick();
        total++; if (rdata !== 8'hAA) begin
            bad++; $display("FAIL rdata_hold: rdata=%h want AA", rdata);
        end
        do_write(3'd2, 8'hFF);
        do_read(3'd2, d, d[0]);
        total++; if (d[7:1] !== 7'h00) begin
            bad++; $display("FAIL in_readonly: rdata=%h want 00", d);
        end
    endtask

    task automatic test_edge_capture();
        logic [WIDTH-1:0] d;
        logic             v;
        do_write(3'd3, 8'h01);
        pad_in = 8'h01;
        tick();
        total++; if (irq !== 1'b0) begin
            bad++; $display("FAIL irq_edge1: irq=%b want 0", irq);
        end
        do_read(3'd2, d, v);
        total++; if (d !== 8'h00 || irq !== 1'b0) begin
            bad++; $display("FAIL in_edge2: rdata=%h irq=%b want 00 0", d, irq);
        end
        do_read(3'd2, d, v);
        total++; if (d !== 8'h01 || irq !== 1'b1) begin
            bad++; $display("FAIL in_edge3: rdata=%h irq=%b want 01 1", d, irq);
        end
        do_read(3'd5, d, v);
        total++; if (d !== 8'h01) begin
            bad++; $display("FAIL flags_rise: rdata=%h want 01", d);
        end
    endtask

    task automatic test_w1c();
        logic [WIDTH-1:0] d;
        logic             v;
        do_write(3'd3, 8'h03);
        pad_in = 8'h03;
        repeat (4) tick();
        do_read(3'd5, d, v);
        total++; if (d !== 8'h03) begin
            bad++; $display("FAIL flags_two: rdata=%h want 03", d);
        end
        do_write(3'd5, 8'h01);
        do_read(3'd5, d, v);
        total++; if (d !== 8'h02 || irq !== 1'b1) begin
            bad++; $display("FAIL w1c_bit0: rdata=%h irq=%b want 02 1", d, irq);
        end
        do_write(3'd5, 8'h02);
        total++; if (irq !== 1'b0) begin
            bad++; $display("FAIL w1c_bit1_irq: irq=%b want 0", irq);
        end
    endtask

    task automatic test_set_wins();
        logic [WIDTH-1:0] d;
        logic             v;
        do_write(3'd4, 8'h02);
        pad_in = 8'h01;
        tick();
        tick();
        do_write(3'd5, 8'h02);
        total++; if (irq !== 1'b1) begin
            bad++; $display("FAIL set_wins_irq: irq=%b want 1", irq);
        end
        do_read(3'd5, d, v);
        total++; if (d !== 8'h02) begin
            bad++; $display("FAIL set_wins_flags: rdata=%h want 02", d);
        end
        do_write(3'd5, 8'h02);
        total++; if (irq !== 1'b0) begin
            bad++; $display("FAIL set_wins_clear: irq=%b want 0", irq);
        end
    endtask

    task automatic test_ena_gating();
        logic [WIDTH-1:0] d;
        logic             v;
        ena = 1'b0;
        pad_in = 8'h00;
        repeat (4) tick();
        pad_in = 8'h01;
        repeat (4) tick();
        total++; if (irq !== 1'b0) begin
            bad++; $display("FAIL ena_low_no_set: irq=%b want 0", irq);
        end
        ena = 1'b1;
        repeat (4) tick();
        do_read(3'd5, d, v);
        total++; if (d !== 8'h00 || irq !== 1'b0) begin
            bad++; $display("FAIL ena_restore_flags: rdata=%h irq=%b want 00 0", d, irq);
        end
    endtask

    task automatic test_reset_mid();
        logic [WIDTH-1:0] d;
        logic             v;
        do_write(3'd0, 8'hFF);
        pad_in = 8'h00;
        repeat (4) tick();
        pad_in = 8'h01;
        repeat (4) tick();
        total++; if (irq !== 1'b1 || pad_oe !== 8'hFF) begin
            bad++; $display("FAIL pre_reset: irq=%b oe=%h want 1 FF", irq, pad_oe);
        end
        rst_n = 1'b0; rd_en = 1'b1; wr_en = 1'b1; addr = 3'd5; wdata = 8'h00;
        tick();
        rd_en = 1'b0; wr_en = 1'b0;
        total++; if (pad_oe !== 8'h00 || pad_out !== 8'h00 || irq !== 1'b0 || rvalid !== 1'b0 || rdata !== 8'h00) begin
            bad++; $display("FAIL mid_reset: oe=%h out=%h irq=%b rvalid=%b rdata=%h want 00 00 0 0 00",
                            pad_oe, pad_out, irq, rvalid, rdata);
        end
        rst_n = 1'b1;
        repeat (4) tick();
        do_read(3'd5, d, v);
        total++; if (d !== 8'h00 || irq !== 1'b0) begin
            bad++; $display("FAIL post_reset_flags: rdata=%h irq=%b want 00 0", d, irq);
        end
        do_read(3'd0, d, v);
        total++; if (d !== 8'h00) begin
            bad++; $display("FAIL post_reset_dir: rdata=%h want 00", d);
        end
    endtask

    initial begin
        test_reset();
        test_outputs();
        test_back_to_back();
        test_edge_capture();
        test_w1c();
        test_set_wins();
        test_ena_gating();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
